// File: rtl/pcie_phy_pkg.sv
// rtl/pcie_phy_pkg.sv - shared constants and state encoding for the serial transmitter
// Contents:
//   SYM_W   : symbol width in bits
//   COM     : idle/training symbol
//   state_t : transmitter state encoding (TRAIN, ACTIVE)
package pcie_phy_pkg;

  localparam int SYM_W = 8;

  localparam logic [SYM_W-1:0] COM = 8'hBC;

  typedef enum logic {
    TRAIN  = 1'b0,
    ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/par_serial_tx_if.sv
// rtl/par_serial_tx_if.sv - byte input and serial output bundle of par_serial_tx
// Signals:
//   data_in, valid_in        : byte stream from the lane mux
//   data_serial, sym_start   : serial bit and first-bit marker
//   sym_is_data, active      : symbol source and training-done status
//   fifo_full, fifo_empty    : buffer occupancy flags
//   overflow                 : sticky dropped-byte flag
// Modports: master drives the byte stream, slave is the transmitter.
interface par_serial_tx_if;
  import pcie_phy_pkg::*;

  logic [SYM_W-1:0] data_in;
  logic             valid_in;
  logic             data_serial;
  logic             sym_start;
  logic             sym_is_data;
  logic             active;
  logic             fifo_full;
  logic             fifo_empty;
  logic             overflow;

  modport master (
    output data_in, valid_in,
    input  data_serial, sym_start, sym_is_data, active, fifo_full, fifo_empty, overflow
  );

  modport slave (
    input  data_in, valid_in,
    output data_serial, sym_start, sym_is_data, active, fifo_full, fifo_empty, overflow
  );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with show-ahead head and push-while-full-with-pop
// Ports:
//   clk, reset_L         : clock, asynchronous active-low reset
//   push, push_data      : write request and data
//   pop, pop_data        : read request and current head (valid when !empty)
//   full, empty          : occupancy flags derived from the entry counter
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // A pop needs data present before the edge; a push into a full FIFO is
  // only legal when a pop frees a slot on the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/par_serial_tx.sv
// rtl/par_serial_tx.sv - byte FIFO plus MSB-first serializer with COM training and idle fill
// Ports:
//   clk      : clock, rising edge
//   reset_L  : asynchronous active-low reset
//   bus      : par_serial_tx_if.slave (byte input, serial output, status flags)
module par_serial_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter logic [pcie_phy_pkg::SYM_W-1:0] COM = pcie_phy_pkg::COM,
  parameter int TRAIN_SYMS = 4
) (
  input  logic          clk,
  input  logic          reset_L,
  par_serial_tx_if.slave bus
);
  import pcie_phy_pkg::*;

  localparam int TCW = $clog2(TRAIN_SYMS + 1);

  state_t           state;
  state_t           state_nx;
  logic [2:0]       bit_cnt;
  logic [SYM_W-1:0] shreg;
  logic [TCW-1:0]   train_cnt;
  logic             sym_is_data;
  logic             overflow;

  logic             boundary;
  logic             take_fifo;
  logic             train_inc;
  logic             fifo_push;
  logic [SYM_W-1:0] fifo_head;
  logic             fifo_full;
  logic             fifo_empty;

  assign boundary = (bit_cnt == 3'd7);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state <= TRAIN;
    else          state <= state_nx;
  end

  // The boundary that finds TRAIN_SYMS COMs already loaded switches to
  // ACTIVE and already picks its symbol the ACTIVE way, so buffered bytes
  // follow the last training COM with no gap.
  always_comb begin
    state_nx  = state;
    take_fifo = 1'b0;
    train_inc = 1'b0;
    if (boundary) begin
      unique case (state)
        TRAIN: begin
          if (train_cnt == TCW'(TRAIN_SYMS)) begin
            state_nx  = ACTIVE;
            take_fifo = !fifo_empty;
          end else begin
            train_inc = 1'b1;
          end
        end
        ACTIVE: take_fifo = !fifo_empty;
        default: state_nx = TRAIN;
      endcase
    end
  end

  // No back-pressure toward the mux: a byte is taken if there is room or a
  // pop frees a slot on this edge, otherwise it is dropped and flagged.
  assign fifo_push = bus.valid_in && (!fifo_full || take_fifo);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      bit_cnt     <= 3'd7;
      shreg       <= '0;
      train_cnt   <= '0;
      sym_is_data <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (boundary) begin
        bit_cnt     <= 3'd0;
        shreg       <= take_fifo ? fifo_head : COM;
        sym_is_data <= take_fifo;
        if (train_inc) train_cnt <= train_cnt + 1'b1;
      end else begin
        bit_cnt <= bit_cnt + 3'd1;
        shreg   <= {shreg[SYM_W-2:0], 1'b0};
      end
      if (bus.valid_in && fifo_full && !take_fifo) overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (SYM_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_L   (reset_L),
    .push      (fifo_push),
    .push_data (bus.data_in),
    .pop       (take_fifo),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.data_serial = shreg[SYM_W-1];
  assign bus.sym_start   = (bit_cnt == 3'd0);
  assign bus.sym_is_data = sym_is_data;
  assign bus.active      = (state == ACTIVE);
  assign bus.fifo_full   = fifo_full;
  assign bus.fifo_empty  = fifo_empty;
  assign bus.overflow    = overflow;

endmodule

// File: doc/par_serial_tx.md
# par_serial_tx

Downstream serializer for the 2:1 8-bit lane mux: consumes the mux's `data_out`/`outValid` byte stream, buffers it in a small FIFO, and shifts one bit per clock onto a single serial line, MSB first. After reset it sends a fixed run of COM (8'hBC) training symbols. When no data is buffered it fills the line with COM. Overflow is flagged rather than back-pressured, because the mux has no ready input.

## Interface
- `FIFO_DEPTH`, 4: byte entries buffered; power of two, ≥2.
- `COM`, 8'hBC: idle/training symbol.
- `TRAIN_SYMS`, 4: COM symbols sent after reset before data may go out.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_L`  in  1  asynchronous, active-low reset.
- `data_in`  in  8  byte from mux `data_out`.
- `valid_in`  in  1  byte qualifier from mux `outValid`.
- `data_serial`  out  1  serial bit, MSB of current symbol first.
- `sym_start`  out  1  high in the cycle `data_serial` carries bit 7 of a symbol.
- `sym_is_data`  out  1  current symbol came from the FIFO (0 = COM).
- `active`  out  1  training complete.
- `fifo_full`  out  1  FIFO holds `FIFO_DEPTH` bytes.
- `fifo_empty`  out  1  FIFO holds 0 bytes.
- `overflow`  out  1  sticky: a valid byte was dropped.

## Operation
- State machine with 2 states: TRAIN (reset state) and ACTIVE.
- 3-bit `bit_cnt` free-runs in both states. Shift register `shreg[7:0]`. `data_serial = shreg[7]`. `sym_start = (bit_cnt == 0)`.
- Load boundary is the edge where `bit_cnt == 7`. At that edge:
  - `bit_cnt` wraps to 0.
  - `shreg` loads the next symbol.
  - Otherwise `shreg <<= 1` and `bit_cnt++`.
- Next symbol selection:
  - TRAIN: load COM and increment the training counter. Once `TRAIN_SYMS` COMs have been loaded, go to ACTIVE at that boundary.
  - ACTIVE, FIFO non-empty: pop head; `sym_is_data = 1` for the whole symbol.
  - ACTIVE, FIFO empty: load COM; `sym_is_data = 0`.
- FIFO write:
  - `valid_in && !fifo_full` pushes `data_in`. Bytes arriving in TRAIN are buffered, not dropped.
  - `valid_in && fifo_full && !pop` drops the byte and sets `overflow`. `overflow` clears only on reset.
  - `valid_in && fifo_full && pop` (same edge) accepts the push; occupancy stays `FIFO_DEPTH`.
- Push and pop on the same edge with an empty FIFO cannot occur: pop requires non-empty before the edge, and there is no bypass.
- Pointers wrap modulo `FIFO_DEPTH`. Occupancy counter is `$clog2(FIFO_DEPTH)+1` bits. Flags are derived from the occupancy counter.

## Timing
- Reset values (asynchronous, while `reset_L` = 0):
  - Registers: state = TRAIN, `bit_cnt` = 7, `shreg` = 0, train count 0, pointers/count 0, `overflow` 0.
  - Outputs: `data_serial` 0, `sym_start` 0, `sym_is_data` 0, `active` 0, `fifo_full` 0, `fifo_empty` 1, `overflow` 0.
- First edge after `reset_L` rises: first COM loads. From the next cycle, `sym_start` = 1 and `data_serial` shows 1,0,1,1,1,1,0,0 over 8 cycles.
- `active` rises on the boundary that loads symbol `TRAIN_SYMS+1`, i.e. `8*TRAIN_SYMS` cycles after the first load.
- Latency: a byte pushed at edge k into an empty FIFO in ACTIVE is popped at the first load boundary strictly after k. Its bit 7 appears 1..8 cycles after k.
- Throughput is 1 byte per 8 clocks. Sustained input faster than that overflows after `FIFO_DEPTH` excess bytes.
- Reset asserted mid-symbol truncates the symbol immediately. FIFO contents are discarded.

## Structure
- Shared package `pcie_phy_pkg` holds:
  - `COM` constant 8'hBC.
  - State encoding (TRAIN = 1'b0, ACTIVE = 1'b1).
  - Symbol width 8.
- One sub-module: `sync_fifo`.
  - Parameters: width 8, depth `FIFO_DEPTH`.
  - Ports: push, pop, data, full, empty, and same-edge push-when-full-with-pop support.
  - Reset: same async active-low reset.
- Top level holds the FSM, `bit_cnt`, `shreg`, training counter and overflow flag.

## Test plan
- Reset release, no input → `data_serial` shows 8'hBC repeated. `sym_start` pulses every 8 cycles. `active` = 1 after 32 cycles. `fifo_empty` stays 1.
- ACTIVE, single push 8'hA5 → next symbol serializes as 1,0,1,0,0,1,0,1 with `sym_is_data` = 1, followed by COM.
- Push 8'h11, 8'h22, 8'h33 during TRAIN → all three held. They are sent in order immediately after the 4th COM, with no COM between them.
- Push 5 bytes back-to-back with `FIFO_DEPTH` = 4 in TRAIN → `fifo_full` = 1 after 4 pushes. 5th byte dropped, `overflow` = 1 and stays 1. First 4 bytes are sent in order.
- Full FIFO in ACTIVE, `valid_in` on a load-boundary edge → byte accepted, `overflow` stays 0, occupancy remains 4.
- `reset_L` pulsed low for 1 cycle mid-data-symbol → all outputs take reset values immediately. Training restarts, and the old FIFO bytes never appear.
